// File: rtl/vd_stim_check_if.sv
// rtl/vd_stim_check_if.sv - symbol/bit handshake between the stimulus harness and the Viterbi decoder
interface vd_stim_check_if #(
  parameter int N_OUT = 2
);
  logic             d_in_valid;
  logic [N_OUT-1:0] d_in;
  logic             d_out_valid;
  logic             d_out;

  modport master (output d_in_valid, d_in, input d_out_valid, d_out);
  modport slave  (input d_in_valid, d_in, output d_out_valid, d_out);
endinterface

// File: rtl/vd_stim_check.sv
// rtl/vd_stim_check.sv - plays a coded frame into the Viterbi decoder and scores the decoded bits
module vd_stim_check #(
  parameter int N_OUT   = 2,
  parameter int N_SYM   = 648,
  parameter int N_BITS  = 628,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic                     start,
  input  logic [N_SYM*N_OUT-1:0]   stim_vec,
  input  logic [N_BITS-1:0]        exp_vec,
  vd_stim_check_if.master          dec,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [31:0]              correct_cnt,
  output logic [31:0]              error_cnt,
  output logic [31:0]              first_err_idx,
  output logic                     timeout,
  output logic                     overrun
);
  localparam int SYM_W  = $clog2(N_SYM + 1);
  localparam int OUT_W  = $clog2(N_BITS + 1);
  localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int SO_W   = (N_SYM * N_OUT > 1) ? $clog2(N_SYM * N_OUT) : 1;
  localparam int EI_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [SYM_W-1:0]   sym_idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [OUT_W-1:0]   out_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               vld_q;
  logic [N_OUT-1:0]   din_q;

  logic start_frame, bit_chk, last_bit, period_end, to_drain, idle_expire, exp_bit;
  logic [SO_W-1:0] sym_off;
  logic [EI_W-1:0] exp_idx;

  assign sym_off     = SO_W'(32'(sym_idx) * N_OUT);
  assign exp_idx     = EI_W'(out_cnt);
  assign exp_bit     = exp_vec[exp_idx];
  assign start_frame = start && (state == S_IDLE || state == S_DONE);
  assign bit_chk     = dec.d_out_valid && (state == S_DRIVE || state == S_DRAIN);
  assign last_bit    = bit_chk && (out_cnt == OUT_W'(N_BITS - 1));
  assign period_end  = (state == S_DRIVE) && (gap_cnt == GAP_W'(GAP));
  assign to_drain    = period_end && (sym_idx == SYM_W'(N_SYM));
  // A bit arriving on the expiry edge counts as activity, so it cancels the timeout.
  assign idle_expire = (state == S_DRAIN) && !dec.d_out_valid && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  assign dec.d_in_valid = vld_q;
  assign dec.d_in       = din_q;
  assign pass = done && (error_cnt == 32'd0) && !timeout && !overrun;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start_frame) state_nxt = S_DRIVE;
      S_DRIVE: begin
        busy = 1'b1;
        if (last_bit)      state_nxt = S_DONE;
        else if (to_drain) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (last_bit || idle_expire) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start_frame) state_nxt = S_DRIVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      vld_q         <= 1'b0;
      din_q         <= '0;
      sym_idx       <= '0;
      gap_cnt       <= '0;
      out_cnt       <= '0;
      idle_cnt      <= '0;
      correct_cnt   <= '0;
      error_cnt     <= '0;
      first_err_idx <= '1;
      timeout       <= 1'b0;
      overrun       <= 1'b0;
    end else if (start_frame) begin
      // Symbol 0 goes out on the start edge itself, so the next one to send is 1.
      vld_q         <= 1'b1;
      din_q         <= stim_vec[N_OUT-1:0];
      sym_idx       <= SYM_W'(1);
      gap_cnt       <= '0;
      out_cnt       <= '0;
      idle_cnt      <= '0;
      correct_cnt   <= '0;
      error_cnt     <= '0;
      first_err_idx <= '1;
      timeout       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (bit_chk) begin
        out_cnt <= out_cnt + OUT_W'(1);
        if (dec.d_out == exp_bit) begin
          if (correct_cnt != '1) correct_cnt <= correct_cnt + 32'd1;
        end else begin
          if (error_cnt != '1) error_cnt <= error_cnt + 32'd1;
          if (first_err_idx == '1) first_err_idx <= 32'(out_cnt);
        end
      end
      case (state)
        S_DRIVE: begin
          if (last_bit || to_drain) begin
            vld_q <= 1'b0;
          end else if (period_end) begin
            vld_q   <= 1'b1;
            din_q   <= stim_vec[sym_off +: N_OUT];
            sym_idx <= sym_idx + SYM_W'(1);
            gap_cnt <= '0;
          end else begin
            vld_q   <= 1'b0;
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_DRAIN: begin
          idle_cnt <= dec.d_out_valid ? '0 : idle_cnt + IDLE_W'(1);
          if (idle_expire) timeout <= 1'b1;
        end
        S_DONE: if (dec.d_out_valid) overrun <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vd_stim_check.sv
// tb/tb_vd_stim_check.sv - randomized frames against a loopback decoder stub and a frame-level model
module tb_vd_stim_check;
  logic clk = 1'b0;
  logic RSTn = 1'b0;
  always #5 clk = ~clk;

  int nout[2]  = '{2, 3};
  int nsym[2]  = '{4, 6};
  int nbits[2] = '{4, 4};
  int gap[2]   = '{0, 2};
  int tmo[2]   = '{16, 16};

  logic        start_r[2], silent[2], inject[2], flip_en[2];
  int          flip_idx[2];
  logic [17:0] stim_r[2];
  logic [3:0]  exp_r[2];

  logic        dv[2], busy_w[2], done_w[2], pass_w[2], to_w[2], ov_w[2], dov[2], dout[2];
  logic [2:0]  din[2];
  logic [31:0] cc[2], ec[2], fe[2];

  vd_stim_check_if #(.N_OUT(2)) ifa ();
  vd_stim_check_if #(.N_OUT(3)) ifb ();

  vd_stim_check #(.N_OUT(2), .N_SYM(4), .N_BITS(4), .GAP(0), .TIMEOUT(16)) u_a (
    .clk(clk), .RSTn(RSTn), .start(start_r[0]), .stim_vec(stim_r[0][7:0]), .exp_vec(exp_r[0]),
    .dec(ifa.master), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .correct_cnt(cc[0]), .error_cnt(ec[0]), .first_err_idx(fe[0]), .timeout(to_w[0]), .overrun(ov_w[0]));

  vd_stim_check #(.N_OUT(3), .N_SYM(6), .N_BITS(4), .GAP(2), .TIMEOUT(16)) u_b (
    .clk(clk), .RSTn(RSTn), .start(start_r[1]), .stim_vec(stim_r[1]), .exp_vec(exp_r[1]),
    .dec(ifb.master), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .correct_cnt(cc[1]), .error_cnt(ec[1]), .first_err_idx(fe[1]), .timeout(to_w[1]), .overrun(ov_w[1]));

  assign dv[0]  = ifa.d_in_valid;
  assign dv[1]  = ifb.d_in_valid;
  assign din[0] = {1'b0, ifa.d_in};
  assign din[1] = ifb.d_in;
  assign ifa.d_out_valid = dov[0];
  assign ifa.d_out       = dout[0];
  assign ifb.d_out_valid = dov[1];
  assign ifb.d_out       = dout[1];

  // Decoder stub: echoes bit 0 of each symbol 3 cycles later, at most N_BITS bits per frame.
  logic [2:0] pv[2], pd[2];
  int         seen[2];
  always @(posedge clk or negedge RSTn) begin
    for (int k = 0; k < 2; k++) begin
      if (!RSTn) begin
        pv[k] <= '0; pd[k] <= '0; seen[k] <= 0;
      end else begin
        pv[k] <= {pv[k][1:0], dv[k]};
        pd[k] <= {pd[k][1:0], din[k][0]};
        if (start_r[k] && !busy_w[k]) seen[k] <= 0;
        else if (dov[k])              seen[k] <= seen[k] + 1;
      end
    end
  end
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      dov[k]  = (pv[k][2] && !silent[k] && seen[k] < nbits[k]) || inject[k];
      dout[k] = pd[k][2] ^ (flip_en[k] && seen[k] == flip_idx[k]);
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int sym(int k, int i);
    logic [17:0] s;
    s = stim_r[k] >> (i * nout[k]);
    return int'(s) & ((1 << nout[k]) - 1);
  endfunction

  task automatic run_frame(input int k, input logic fl, input int fi, input logic [3:0] noise,
                           input logic sil, input logic ign, input logic coinc);
    int vcyc[$], vsym[$];
    int cyc, nsent, c_last, done_cyc, ecorr, eerr, efirst, dbit;
    logic eto;
    repeat (4) @(negedge clk);
    stim_r[k] = 18'($urandom);
    for (int j = 0; j < 4; j++) exp_r[k][j] = 1'(sym(k, j)) ^ noise[j];
    flip_en[k] = fl; flip_idx[k] = fi; silent[k] = sil;
    start_r[k] = 1'b1;
    inject[k] = coinc;
    @(negedge clk);
    start_r[k] = 1'b0;
    inject[k] = 1'b0;
    cyc = 1;
    check("busy_at_c1", 32'(busy_w[k]), 32'd1);
    while (!done_w[k] && cyc < 400) begin
      if (dv[k]) begin vcyc.push_back(cyc); vsym.push_back(int'(din[k])); end
      start_r[k] = ign && cyc == 2;
      @(negedge clk);
      cyc++;
    end
    start_r[k] = 1'b0;
    ecorr = 0; eerr = 0; efirst = -1;
    if (sil) begin
      nsent = nsym[k];
      done_cyc = nsym[k] * (gap[k] + 1) + 1 + tmo[k];
      eto = 1'b1;
    end else begin
      c_last = (nbits[k] - 1) * (gap[k] + 1) + 1 + 3;
      nsent = (c_last - 1) / (gap[k] + 1) + 1;
      if (nsent > nsym[k]) nsent = nsym[k];
      done_cyc = c_last + 1;
      eto = 1'b0;
      for (int j = 0; j < nbits[k]; j++) begin
        dbit = (sym(k, j) & 1) ^ int'(fl && j == fi);
        if (dbit == int'(exp_r[k][j])) ecorr++;
        else begin eerr++; if (efirst < 0) efirst = j; end
      end
    end
    check("done_cycle", 32'(cyc), 32'(done_cyc));
    check("sym_count", 32'(vcyc.size()), 32'(nsent));
    for (int i = 0; i < vcyc.size() && i < nsent; i++) begin
      check("sym_cycle", 32'(vcyc[i]), 32'(i * (gap[k] + 1) + 1));
      check("sym_value", 32'(vsym[i]), 32'(sym(k, i)));
    end
    check("correct_cnt", cc[k], 32'(ecorr));
    check("error_cnt", ec[k], 32'(eerr));
    check("first_err_idx", fe[k], 32'(efirst));
    check("timeout", 32'(to_w[k]), 32'(eto));
    check("overrun", 32'(ov_w[k]), 32'd0);
    check("pass", 32'(pass_w[k]), 32'(!eto && eerr == 0));
    check("busy_done", 32'(busy_w[k]), 32'd0);
    check("valid_done", 32'(dv[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_r[k] = 0; silent[k] = 0; inject[k] = 0; flip_en[k] = 0; flip_idx[k] = 0;
      stim_r[k] = 18'($urandom); exp_r[k] = 4'($urandom);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", 32'(dv[k]), 32'd0);
      check("rst_d_in", 32'(din[k]), 32'd0);
      check("rst_busy", 32'(busy_w[k]), 32'd0);
      check("rst_done", 32'(done_w[k]), 32'd0);
      check("rst_pass", 32'(pass_w[k]), 32'd0);
      check("rst_cnts", cc[k] | ec[k], 32'd0);
      check("rst_first_err", fe[k], 32'hFFFF_FFFF);
      check("rst_flags", 32'({to_w[k], ov_w[k]}), 32'd0);
    end
    RSTn = 1'b1;

    run_frame(0, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    run_frame(1, 1'b1, 2, 4'h0, 1'b0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    silent[0] = 1'b0;

    run_frame(0, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); inject[0] = 1'b1;
    @(negedge clk); inject[0] = 1'b0;
    check("overrun_set", 32'(ov_w[0]), 32'd1);
    check("overrun_pass", 32'(pass_w[0]), 32'd0);
    check("overrun_done", 32'(done_w[0]), 32'd1);
    check("overrun_cc", cc[0], 32'd4);
    run_frame(0, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    stim_r[0] = 18'($urandom);
    start_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mid_sym2_valid", 32'(dv[0]), 32'd1);
    RSTn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(dv[0]), 32'd0);
    check("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk); RSTn = 1'b1;
    run_frame(0, 1'b0, 0, 4'h0, 1'b0, 1'b1, 1'b0);

    for (int it = 0; it < 8; it++) begin
      int k;
      k = it % 2;
      run_frame(k, 1'($urandom), int'($urandom_range(0, 3)),
                $urandom_range(0, 1) ? 4'($urandom) : 4'h0, 1'b0, 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
